sar_search_ctrl: RTL and testbench
==================================

Name: sar_search_ctrl

Overview:
- Sequential successive-approximation controller that drives the "a" side of a magnitude comparator with trial values.
- Consumes the comparator's less/equal/greater flags and binary-searches for the unknown value presented on the comparator's "b" side.
- It is the consumer end of the comparator interface: it owns the operands and reads back the relation flags.
- Used for value discovery, e.g. matching a threshold or locating a DAC code.

Parameters:
- WIDTH, 4, operand width in bits; the search covers 0 .. 2^WIDTH-1.
- SETTLE, 0, extra wait cycles after each new guess before the flags are sampled (0..15), for registered or slow comparators.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a search; sampled only in IDLE.
- guess  output  WIDTH  trial operand to comparator input a.
- cmp_less  input  1  guess < target.
- cmp_equal  input  1  guess == target.
- cmp_greater  input  1  guess > target.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when a search completes (success, not-found or error).
- result  output  WIDTH  final value; held until the next start.
- found  output  1  result confirmed by cmp_equal; held until the next start.
- error  output  1  flags were not one-hot during a sample; held until the next start.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-search):
  - state=IDLE; guess, result, busy, done, found, error all 0; wait counter 0.
- States: IDLE, PROBE, WAIT, VERIFY, FINISH.
- IDLE:
  - guess=0.
  - start=1: bit index = WIDTH-1; guess = 1<<(WIDTH-1); clear found/error/result; busy=1.
  - Next state is WAIT if SETTLE>0, otherwise PROBE.
- WAIT:
  - Counts SETTLE cycles with guess held stable.
  - Then returns to PROBE, or to VERIFY when verifying.
- PROBE (flags sampled on this cycle's edge):
  - Flags not exactly one-hot (none, or more than one set): error=1, go to FINISH.
  - cmp_equal: result=guess, found=1, go to FINISH (early exit).
  - cmp_greater: clear the current bit. cmp_less: keep it.
  - If bit index > 0: decrement it, set the next lower bit in guess, go to WAIT or PROBE.
  - If bit index = 0: guess = decided value, go to WAIT or VERIFY.
- VERIFY:
  - Samples the flags once more.
  - cmp_equal: found=1.
  - Otherwise found=0 (target changed mid-search).
  - Non-one-hot flags: error=1.
  - result=guess in all cases; go to FINISH.
- FINISH: done=1 for exactly one cycle; busy=0 from the next cycle; guess returns to 0; go to IDLE.
- Latency: start to done is at most (WIDTH+1)*(SETTLE+1)+1 cycles. With WIDTH=4 and SETTLE=0 the worst case is 6 cycles.
- start while busy is ignored. start in the FINISH cycle is ignored; the earliest accepted start is the cycle after done.
- The flags are treated as combinational on guess. guess changes only on clock edges and is never X after reset.
- The wait counter width is 4 bits; SETTLE values above 15 are illegal (elaboration check).

Decomposition:
- Shared package:
  - state enum/localparams (IDLE, PROBE, WAIT, VERIFY, FINISH).
  - flag one-hot check function.
  - default WIDTH constant shared with the comparator.
- No sub-module is required in the controller.
- The bench instantiates the existing 4-bit behavioural comparator as the DUT's partner, with its a input tied to guess and its b input tied to the target.

Test Plan:
- Target 11, SETTLE=0, pulse start → guess sequence 8,12,10,11; equal on the 4th probe; done with result=11, found=1, error=0; busy for 4 cycles.
- Target 0 → guesses 8,4,2,1, then VERIFY at 0 → equal; result=0, found=1; done 6 cycles after start.
- Target 15, SETTLE=2 → guesses 8,12,14,15, each held 3 cycles; result=15, found=1; flags are never sampled during the WAIT cycles.
- Force cmp_less and cmp_greater both high on the 2nd probe → error=1, found=0, done pulse, busy=0 the following cycle.
- Assert rst asynchronously mid-search (after guess=12) → all outputs 0 immediately, without waiting for a clock edge; a new start afterwards with target 5 gives result=5, found=1.
- start held high continuously with target 3 → back-to-back searches each return result=3; starts during busy or in the FINISH cycle have no effect.

Source files
------------

// File: rtl/sar_search_ctrl_pkg.sv
// Shared definitions for the successive-approximation search controller and
// the magnitude comparator it talks to.
package sar_search_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W         = 4;
  localparam int SETTLE_MAX    = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PROBE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Exactly one of the three relation flags may be set for a valid compare.
  function automatic logic flags_onehot(input logic less, input logic equal, input logic greater);
    return (less ^ equal ^ greater) & ~(less & equal & greater);
  endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Controller <-> comparator/host bundle: trial operand out, relation flags in,
// plus the search handshake and result.
interface sar_search_ctrl_if
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             cmp_less;
  logic             cmp_equal;
  logic             cmp_greater;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             error;

  modport master (
    input  start, cmp_less, cmp_equal, cmp_greater,
    output guess, busy, done, result, found, error
  );

  modport slave (
    output start, cmp_less, cmp_equal, cmp_greater,
    input  guess, busy, done, result, found, error
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Binary search over 0 .. 2^WIDTH-1 driving comparator operand a, one bit per
// probe, with an optional settle delay before every flag sample.
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  sar_search_ctrl_if.master bus
);

  localparam int               BW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic             HAS_WAIT    = (SETTLE > 0);
  localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : CNT_W'(0);
  localparam logic [WIDTH-1:0] GUESS_MSB   = {1'b1, {(WIDTH-1){1'b0}}};

  if (SETTLE < 0 || SETTLE > SETTLE_MAX) begin : g_settle_range
    $error("sar_search_ctrl: SETTLE must be within 0..15");
  end

  state_t           state_r, state_s;
  logic [WIDTH-1:0] guess_r, guess_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [WIDTH-1:0] decided_s;
  logic [BW-1:0]    bit_r, bit_s, bit_dn_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             verify_r, verify_s;
  logic             found_r, found_s;
  logic             error_r, error_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             onehot_s;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      guess_r  <= '0;
      result_r <= '0;
      bit_r    <= '0;
      cnt_r    <= '0;
      verify_r <= 1'b0;
      found_r  <= 1'b0;
      error_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      guess_r  <= guess_s;
      result_r <= result_s;
      bit_r    <= bit_s;
      cnt_r    <= cnt_s;
      verify_r <= verify_s;
      found_r  <= found_s;
      error_r  <= error_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    guess_s   = guess_r;
    result_s  = result_r;
    bit_s     = bit_r;
    cnt_s     = cnt_r;
    verify_s  = verify_r;
    found_s   = found_r;
    error_s   = error_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    onehot_s  = flags_onehot(bus.cmp_less, bus.cmp_equal, bus.cmp_greater);
    bit_dn_s  = bit_r - BW'(1);
    decided_s = guess_r;
    if (bus.cmp_greater) begin
      decided_s[bit_r] = 1'b0;
    end else begin
      decided_s[bit_r] = guess_r[bit_r];
    end

    case (state_r)
      ST_IDLE: begin
        guess_s = '0;
        if (bus.start) begin
          bit_s    = BW'(WIDTH - 1);
          guess_s  = GUESS_MSB;
          result_s = '0;
          found_s  = 1'b0;
          error_s  = 1'b0;
          busy_s   = 1'b1;
          verify_s = 1'b0;
          cnt_s    = '0;
          state_s  = HAS_WAIT ? ST_WAIT : ST_PROBE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == SETTLE_LAST) begin
          cnt_s   = '0;
          state_s = verify_r ? ST_VERIFY : ST_PROBE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_PROBE: begin
        if (!onehot_s) begin
          error_s = 1'b1;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          guess_s = '0;
          state_s = ST_FINISH;
        end else if (bus.cmp_equal) begin
          result_s = guess_r;
          found_s  = 1'b1;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          guess_s  = '0;
          state_s  = ST_FINISH;
        end else if (bit_r != '0) begin
          bit_s             = bit_dn_s;
          guess_s           = decided_s;
          guess_s[bit_dn_s] = 1'b1;
          state_s           = HAS_WAIT ? ST_WAIT : ST_PROBE;
        end else begin
          // Last bit decided: re-check the final value before reporting it.
          guess_s  = decided_s;
          verify_s = 1'b1;
          state_s  = HAS_WAIT ? ST_WAIT : ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        result_s = guess_r;
        found_s  = onehot_s & bus.cmp_equal;
        error_s  = ~onehot_s;
        busy_s   = 1'b0;
        done_s   = 1'b1;
        guess_s  = '0;
        state_s  = ST_FINISH;
      end
      ST_FINISH: begin
        guess_s = '0;
        state_s = ST_IDLE;
      end
      default: begin
        guess_s = '0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  assign bus.guess  = guess_r;
  assign bus.result = result_r;
  assign bus.found  = found_r;
  assign bus.error  = error_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench: two controllers (SETTLE=0 and SETTLE=2), each paired with a
// behavioural 4-bit comparator whose b side is the bench target.
module tb_sar_search_ctrl;

  logic       clk;
  logic       rst;
  logic       start_v;
  logic       sel;
  logic       force0;
  logic [3:0] target;

  int checks   = 0;
  int failures = 0;
  int dones;
  int last_done;

  logic [3:0] exp_q[$];

  sar_search_ctrl_if #(.WIDTH(4)) bus0 ();
  sar_search_ctrl_if #(.WIDTH(4)) bus2 ();

  sar_search_ctrl #(.WIDTH(4), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sar_search_ctrl #(.WIDTH(4), .SETTLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.start       = start_v & ~sel;
  assign bus2.start       = start_v & sel;
  assign bus0.cmp_less    = force0 | (bus0.guess < target);
  assign bus0.cmp_greater = force0 | (bus0.guess > target);
  assign bus0.cmp_equal   = ~force0 & (bus0.guess == target);
  assign bus2.cmp_less    = bus2.guess < target;
  assign bus2.cmp_greater = bus2.guess > target;
  assign bus2.cmp_equal   = bus2.guess == target;

  logic [3:0] v_guess, v_result;
  logic       v_busy, v_done, v_found, v_error;
  assign v_guess  = sel ? bus2.guess  : bus0.guess;
  assign v_result = sel ? bus2.result : bus0.result;
  assign v_busy   = sel ? bus2.busy   : bus0.busy;
  assign v_done   = sel ? bus2.done   : bus0.done;
  assign v_found  = sel ? bus2.found  : bus0.found;
  assign v_error  = sel ? bus2.error  : bus0.error;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Pulse start, follow the guess sequence in exp_q, then check the outcome.
  task automatic run_search(input string tag, input logic s, input logic [3:0] tgt,
                            input int exp_lat, input logic [3:0] exp_res, input logic exp_found);
    int n;
    sel    = s;
    target = tgt;
    @(negedge clk) start_v = 1'b1;
    @(negedge clk) start_v = 1'b0;
    n = 1;
    while (!v_done && n < 40) begin
      if (n <= exp_q.size()) begin
        chk({tag, "_guess"}, 32'(v_guess), 32'(exp_q[n-1]));
        chk({tag, "_busy"}, 32'(v_busy), 32'd1);
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_done"}, 32'(v_done), 32'd1);
    chk({tag, "_result"}, 32'(v_result), 32'(exp_res));
    chk({tag, "_found"}, 32'(v_found), 32'(exp_found));
    chk({tag, "_error"}, 32'(v_error), 32'd0);
    chk({tag, "_busy_end"}, 32'(v_busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_low"}, 32'(v_done), 32'd0);
    chk({tag, "_guess_idle"}, 32'(v_guess), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start_v = 1'b0;
    sel     = 1'b0;
    force0  = 1'b0;
    target  = 4'd0;
    #12;
    chk("rst_guess0", 32'(bus0.guess), 32'd0);
    chk("rst_busy0", 32'(bus0.busy), 32'd0);
    chk("rst_done0", 32'(bus0.done), 32'd0);
    chk("rst_result0", 32'(bus0.result), 32'd0);
    chk("rst_found0", 32'(bus0.found), 32'd0);
    chk("rst_error0", 32'(bus0.error), 32'd0);
    chk("rst_guess2", 32'(bus2.guess), 32'd0);
    chk("rst_busy2", 32'(bus2.busy), 32'd0);
    @(negedge clk) rst = 1'b0;

    exp_q = '{4'd8, 4'd12, 4'd10, 4'd11};
    run_search("t11", 1'b0, 4'd11, 5, 4'd11, 1'b1);

    exp_q = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd0};
    run_search("t0", 1'b0, 4'd0, 6, 4'd0, 1'b1);

    exp_q = '{4'd8, 4'd8, 4'd8, 4'd12, 4'd12, 4'd12, 4'd14, 4'd14, 4'd14, 4'd15, 4'd15, 4'd15};
    run_search("s2_t15", 1'b1, 4'd15, 13, 4'd15, 1'b1);

    // Both less and greater forced high on the second probe.
    sel    = 1'b0;
    target = 4'd11;
    @(negedge clk) start_v = 1'b1;
    @(negedge clk) start_v = 1'b0;
    chk("err_probe1", 32'(bus0.guess), 32'd8);
    @(negedge clk);
    chk("err_probe2", 32'(bus0.guess), 32'd12);
    force0 = 1'b1;
    @(negedge clk);
    force0 = 1'b0;
    chk("err_done", 32'(bus0.done), 32'd1);
    chk("err_error", 32'(bus0.error), 32'd1);
    chk("err_found", 32'(bus0.found), 32'd0);
    chk("err_busy", 32'(bus0.busy), 32'd0);
    @(negedge clk);
    chk("err_done_low", 32'(bus0.done), 32'd0);
    chk("err_busy_after", 32'(bus0.busy), 32'd0);
    chk("err_error_held", 32'(bus0.error), 32'd1);

    // Asynchronous reset between clock edges mid-search.
    @(negedge clk) start_v = 1'b1;
    @(negedge clk) start_v = 1'b0;
    @(negedge clk);
    chk("arst_pre_guess", 32'(bus0.guess), 32'd12);
    #2 rst = 1'b1;
    #1;
    chk("arst_guess", 32'(bus0.guess), 32'd0);
    chk("arst_busy", 32'(bus0.busy), 32'd0);
    chk("arst_done", 32'(bus0.done), 32'd0);
    chk("arst_result", 32'(bus0.result), 32'd0);
    chk("arst_found", 32'(bus0.found), 32'd0);
    chk("arst_error", 32'(bus0.error), 32'd0);
    @(negedge clk) rst = 1'b0;

    exp_q = '{4'd8, 4'd4, 4'd6, 4'd5};
    run_search("t5", 1'b0, 4'd5, 5, 4'd5, 1'b1);

    // start held high: a new search every six cycles, each returning 3.
    sel       = 1'b0;
    target    = 4'd3;
    dones     = 0;
    last_done = 0;
    @(negedge clk) start_v = 1'b1;
    for (int c = 1; c <= 40 && dones < 3; c++) begin
      @(negedge clk);
      if (bus0.done) begin
        chk("b2b_result", 32'(bus0.result), 32'd3);
        chk("b2b_found", 32'(bus0.found), 32'd1);
        if (dones > 0) begin
          chk("b2b_gap", 32'(c - last_done), 32'd6);
        end
        last_done = c;
        dones++;
      end
    end
    start_v = 1'b0;
    chk("b2b_count", 32'(dones), 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(bus0.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
